// File: rtl/repetition_link_pkg.sv
// repetition_link_pkg: shared state encoding and link constants for the triple-repetition serial link
package repetition_link_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2} state_t;
    localparam int DEF_NBITS = 8;
    localparam int DEF_REPEAT = 3;
    localparam logic START_LEVEL = 1'b1;
endpackage

// File: rtl/tx_symbol_counter.sv
// tx_symbol_counter: chip-within-symbol and bit-within-frame counters with terminal-count flags
module tx_symbol_counter
    import repetition_link_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int REPEAT = DEF_REPEAT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_en,
    output logic chip_last,
    output logic bit_last
);
    localparam int CW = REPEAT > 1 ? $clog2(REPEAT) : 1;
    localparam int BW = NBITS > 1 ? $clog2(NBITS) : 1;
    logic [CW-1:0] chip_q, chip_d;
    logic [BW-1:0] bit_q, bit_d;
    assign chip_last = chip_q == CW'(REPEAT - 1);
    assign bit_last = bit_q == BW'(NBITS - 1);
    always_comb begin
        chip_d = !en ? chip_q : chip_last ? '0 : chip_q + CW'(1);
        bit_d = !(bit_en && chip_last) ? bit_q : bit_last ? '0 : bit_q + BW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            chip_q <= '0;
            bit_q <= '0;
        end else begin
            chip_q <= chip_d;
            bit_q <= bit_d;
        end
    end
endmodule

// File: rtl/repetition_code_tx.sv
// repetition_code_tx: frames a word with a start symbol and sends it LSB-first, each bit repeated REPEAT chips
module repetition_code_tx
    import repetition_link_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int REPEAT = DEF_REPEAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_data,
    output logic             tx_out,
    output logic             tx_val,
    output logic             busy
);
    if (REPEAT < 3 || REPEAT % 2 == 0 || NBITS < 1) begin : g_bad_params
        $error("repetition_code_tx: REPEAT must be odd and >= 3, NBITS >= 1");
    end
    state_t state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic tx_out_q, tx_out_d, busy_q, busy_d;
    logic chip_last, bit_last;
    tx_symbol_counter #(.NBITS(NBITS), .REPEAT(REPEAT)) u_cnt (
        .clk(clk),
        .rst(rst),
        .en(state_q != IDLE),
        .bit_en(state_q == DATA),
        .chip_last(chip_last),
        .bit_last(bit_last)
    );
    assign in_rdy = state_q == IDLE && !rst;
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: if (in_val) begin
                state_d = START;
                shift_d = in_data;
            end
            START: state_d = chip_last ? DATA : START;
            DATA: if (chip_last) begin
                shift_d = shift_q >> 1;
                state_d = bit_last ? IDLE : DATA;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so the line changes exactly on symbol boundaries
        tx_out_d = state_d == START ? START_LEVEL : state_d == DATA && shift_d[0];
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            tx_out_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tx_out_q <= tx_out_d;
            busy_q <= busy_d;
        end
    end
    assign tx_out = tx_out_q;
    assign tx_val = busy_q;
    assign busy = busy_q;
endmodule
